// File: rtl/pong_collision_scorer.sv
// Collision, miss and score stage for the pong ball loop: paddle bounces, point scoring, serve/play/game-over sequencing.
// Optional feature: define RALLY_COUNTER_EN to add the rallyCount output.
module pong_collision_scorer #(
  parameter int LEFT_PADDLE_X      = 20,
  parameter int RIGHT_PADDLE_X     = 220,
  parameter int PADDLE_HALF_WIDTH  = 5,
  parameter int BALL_HALF_SIZE     = 5,
  parameter int PADDLE_HALF_LENGTH = 20,
  parameter int LEFT_MISS_X        = 10,
  parameter int RIGHT_MISS_X       = 230,
  parameter int SCREEN_WIDTH       = 240,
  parameter int SERVE_HOLD_CYCLES  = 16,
  parameter int WIN_SCORE          = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ballXValue,
  input  logic [8:0] ballYValue,
  input  logic       ballDirection,
  input  logic [8:0] leftPaddleY,
  input  logic [8:0] rightPaddleY,
  input  logic       newGame,
  output logic       changeXDirection,
  output logic [1:0] changeYDirection,
  output logic       serveReset,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic       gameOver
`ifdef RALLY_COUNTER_EN
  ,
  output logic [7:0] rallyCount
`endif
);

  localparam int CW = (SERVE_HOLD_CYCLES > 2) ? $clog2(SERVE_HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] SERVE_RELOAD = CW'(SERVE_HOLD_CYCLES - 1);
  localparam logic [7:0] RIGHT_HIT_LO = 8'(RIGHT_PADDLE_X - PADDLE_HALF_WIDTH - BALL_HALF_SIZE);
  localparam logic [7:0] RIGHT_HIT_HI = 8'(RIGHT_PADDLE_X);
  localparam logic [7:0] LEFT_HIT_LO  = 8'(LEFT_PADDLE_X);
  localparam logic [7:0] LEFT_HIT_HI  = 8'(LEFT_PADDLE_X + PADDLE_HALF_WIDTH + BALL_HALF_SIZE);
  localparam logic [7:0] LEFT_MISS    = 8'(LEFT_MISS_X);
  localparam logic [7:0] RIGHT_MISS   = 8'(RIGHT_MISS_X);
  localparam logic [7:0] WRAP_X       = 8'(SCREEN_WIDTH);
  localparam logic [9:0] Y_REACH      = 10'(PADDLE_HALF_LENGTH + BALL_HALF_SIZE);
  localparam logic [3:0] WIN          = 4'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE, PLAY, GAME_OVER} stateT;

  stateT stateReg, stateNext;
  logic [CW-1:0] counterReg, counterNext;
  logic hitLockReg, hitLockNext, hitDirReg, hitDirNext;
  logic changeXNext;
  logic [1:0] changeYNext;
  logic [3:0] leftScoreNext, rightScoreNext;

  function automatic logic [9:0] absVal(input logic signed [9:0] v);
    return v[9] ? 10'(-v) : 10'(v);
  endfunction

  // Which half of the paddle was struck: above centre, below centre, or dead centre.
  function automatic logic [1:0] yCode(input logic signed [9:0] v);
    if (v[9]) return 2'b10;
    else if (v != 10'sd0) return 2'b01;
    else return 2'b00;
  endfunction

  function automatic logic [3:0] satInc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  logic signed [9:0] leftDy, rightDy;
  logic leftHit, rightHit, leftMiss, rightMiss;

  assign leftDy  = $signed({1'b0, ballYValue}) - $signed({1'b0, leftPaddleY});
  assign rightDy = $signed({1'b0, ballYValue}) - $signed({1'b0, rightPaddleY});

  assign rightHit  = ballDirection && (ballXValue >= RIGHT_HIT_LO) && (ballXValue <= RIGHT_HIT_HI)
                     && (absVal(rightDy) <= Y_REACH);
  assign leftHit   = !ballDirection && (ballXValue >= LEFT_HIT_LO) && (ballXValue <= LEFT_HIT_HI)
                     && (absVal(leftDy) <= Y_REACH);
  assign rightMiss = ballDirection && (ballXValue > RIGHT_MISS);
  // X values at or past the screen width are a left-moving ball that wrapped below zero.
  assign leftMiss  = !ballDirection && ((ballXValue < LEFT_MISS) || (ballXValue >= WRAP_X));

  always_comb begin
    stateNext      = stateReg;
    counterNext    = counterReg;
    hitLockNext    = hitLockReg;
    hitDirNext     = hitDirReg;
    changeXNext    = 1'b0;
    changeYNext    = 2'b00;
    leftScoreNext  = leftScore;
    rightScoreNext = rightScore;
    if (newGame) begin
      leftScoreNext  = 4'd0;
      rightScoreNext = 4'd0;
      stateNext      = SERVE;
      counterNext    = SERVE_RELOAD;
      hitLockNext    = 1'b0;
    end else begin
      case (stateReg)
        SERVE: begin
          hitLockNext = 1'b0;
          if (counterReg == '0) stateNext = PLAY;
          else counterNext = counterReg - CW'(1);
        end
        PLAY: begin
          if (hitLockReg && (ballDirection != hitDirReg)) hitLockNext = 1'b0;
          if (!hitLockReg && (rightHit || leftHit)) begin
            changeXNext = 1'b1;
            changeYNext = rightHit ? yCode(rightDy) : yCode(leftDy);
            hitLockNext = 1'b1;
            hitDirNext  = ballDirection;
          end else if (rightMiss) begin
            leftScoreNext = satInc(leftScore);
            stateNext     = (leftScoreNext == WIN) ? GAME_OVER : SERVE;
            counterNext   = SERVE_RELOAD;
          end else if (leftMiss) begin
            rightScoreNext = satInc(rightScore);
            stateNext      = (rightScoreNext == WIN) ? GAME_OVER : SERVE;
            counterNext    = SERVE_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg         <= SERVE;
      counterReg       <= SERVE_RELOAD;
      hitLockReg       <= 1'b0;
      hitDirReg        <= 1'b0;
      changeXDirection <= 1'b0;
      changeYDirection <= 2'b00;
      serveReset       <= 1'b1;
      leftScore        <= 4'd0;
      rightScore       <= 4'd0;
      gameOver         <= 1'b0;
    end else begin
      stateReg         <= stateNext;
      counterReg       <= counterNext;
      hitLockReg       <= hitLockNext;
      hitDirReg        <= hitDirNext;
      changeXDirection <= changeXNext;
      changeYDirection <= changeYNext;
      serveReset       <= (stateNext != PLAY);
      leftScore        <= leftScoreNext;
      rightScore       <= rightScoreNext;
      gameOver         <= (stateNext == GAME_OVER);
    end
  end

`ifdef RALLY_COUNTER_EN
  logic [7:0] rallyReg;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rallyReg <= 8'd0;
    else if ((stateNext == SERVE) && (stateReg != SERVE)) rallyReg <= 8'd0;
    else if (changeXNext && (rallyReg != 8'hFF)) rallyReg <= rallyReg + 8'd1;
  end
  assign rallyCount = rallyReg;
`endif

endmodule

// File: tb/tb_pong_collision_scorer.sv
// Directed bench for pong_collision_scorer: bounces, lockout, misses, game over, newGame and async reset.
// Define RALLY_COUNTER_EN to also check rallyCount.
module tb_pong_collision_scorer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ballXValue;
  logic [8:0] ballYValue;
  logic       ballDirection;
  logic [8:0] leftPaddleY;
  logic [8:0] rightPaddleY;
  logic       newGame;
  logic       changeXDirection;
  logic [1:0] changeYDirection;
  logic       serveReset;
  logic [3:0] leftScore;
  logic [3:0] rightScore;
  logic       gameOver;
`ifdef RALLY_COUNTER_EN
  logic [7:0] rallyCount;
`endif

  int checks = 0;
  int failures = 0;

  pong_collision_scorer dut (
    .clock            (clock),
    .reset            (reset),
    .ballXValue       (ballXValue),
    .ballYValue       (ballYValue),
    .ballDirection    (ballDirection),
    .leftPaddleY      (leftPaddleY),
    .rightPaddleY     (rightPaddleY),
    .newGame          (newGame),
    .changeXDirection (changeXDirection),
    .changeYDirection (changeYDirection),
    .serveReset       (serveReset),
    .leftScore        (leftScore),
    .rightScore       (rightScore),
    .gameOver         (gameOver)
`ifdef RALLY_COUNTER_EN
    ,
    .rallyCount       (rallyCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ballXValue    = 8'd120;
    ballDirection = 1'b1;
  endtask

  task automatic checkRally(input string tag, input int exp);
`ifdef RALLY_COUNTER_EN
    check(tag, 32'(rallyCount), exp);
`endif
  endtask

  // serveReset stays high for 15 further cycles, then drops as PLAY is entered
  task automatic serveWindow(input string tag);
    for (int i = 0; i < 15; i++) begin
      step();
      check({tag, "_hold"}, 32'(serveReset), 1);
    end
    step();
    check({tag, "_release"}, 32'(serveReset), 0);
  endtask

  task automatic hitStep(input string tag, input int expX, input int expY);
    step();
    check({tag, "_x"}, 32'(changeXDirection), expX);
    check({tag, "_y"}, 32'(changeYDirection), expY);
  endtask

  initial begin
    reset = 1'b0;
    newGame = 1'b0;
    ballYValue = 9'd240;
    leftPaddleY = 9'd240;
    rightPaddleY = 9'd240;
    idle();
    #12;
    check("rst_changeX", 32'(changeXDirection), 0);
    check("rst_changeY", 32'(changeYDirection), 0);
    check("rst_left", 32'(leftScore), 0);
    check("rst_right", 32'(rightScore), 0);
    check("rst_gameOver", 32'(gameOver), 0);
    check("rst_serve", 32'(serveReset), 1);
    checkRally("rst_rally", 0);
    reset = 1'b1;
    serveWindow("boot");

    // right paddle hit above centre, then lockout for held inputs
    ballXValue = 8'd212; ballYValue = 9'd240; rightPaddleY = 9'd250;
    hitStep("rhit", 1, 2);
    for (int i = 0; i < 4; i++) hitStep("rhit_lock", 0, 0);
    ballDirection = 1'b0;
    hitStep("rhit_dirflip", 0, 0);
    ballDirection = 1'b1;
    hitStep("rhit_rearm", 1, 2);
    ballDirection = 1'b0; ballXValue = 8'd120;
    hitStep("away_left", 0, 0);

    // left paddle hits: below centre, out of reach, reach boundary, dead centre
    ballXValue = 8'd25; ballYValue = 9'd270; leftPaddleY = 9'd260;
    hitStep("lhit", 1, 1);
    checkRally("rally_3", 3);
    idle();
    hitStep("clear1", 0, 0);
    ballDirection = 1'b0; ballXValue = 8'd25; ballYValue = 9'd300;
    hitStep("lhit_far", 0, 0);
    ballYValue = 9'd285;
    hitStep("lhit_edge", 1, 1);
    idle();
    hitStep("clear2", 0, 0);
    ballDirection = 1'b0; ballXValue = 8'd25; ballYValue = 9'd260;
    hitStep("lhit_centre", 1, 0);
    idle();
    hitStep("clear3", 0, 0);
    ballDirection = 1'b0; ballXValue = 8'd31;
    hitStep("lhit_x_out", 0, 0);
    ballXValue = 8'd19;
    hitStep("lhit_x_low", 0, 0);

    // right X boundaries
    ballDirection = 1'b1; ballXValue = 8'd221; ballYValue = 9'd240; rightPaddleY = 9'd250;
    hitStep("rhit_x_out", 0, 0);
    ballXValue = 8'd210; ballYValue = 9'd225;
    hitStep("rhit_edge", 1, 2);
    checkRally("rally_6", 6);

    // right miss: left scores once, serve held while the ball stays past the line
    ballXValue = 8'd231;
    step();
    check("rmiss_left", 32'(leftScore), 1);
    check("rmiss_serve", 32'(serveReset), 1);
    check("rmiss_x", 32'(changeXDirection), 0);
    checkRally("rmiss_rally", 0);
    serveWindow("rmiss");
    idle();
    check("rmiss_single", 32'(leftScore), 1);

    ballXValue = 8'd230;
    step();
    check("rmiss_bound_serve", 32'(serveReset), 0);
    check("rmiss_bound_left", 32'(leftScore), 1);
    ballDirection = 1'b0; ballXValue = 8'd10;
    step();
    check("lmiss_bound_serve", 32'(serveReset), 0);
    check("lmiss_bound_right", 32'(rightScore), 0);

    ballXValue = 8'd250;
    step();
    check("wrap_right", 32'(rightScore), 1);
    check("wrap_serve", 32'(serveReset), 1);
    idle();
    serveWindow("wrap");
    ballDirection = 1'b0; ballXValue = 8'd9;
    step();
    check("lmiss_right", 32'(rightScore), 2);
    idle();
    serveWindow("lmiss");

    // drive left score up to 8, then the winning point
    for (int k = 2; k <= 8; k++) begin
      ballDirection = 1'b1; ballXValue = 8'd231;
      step();
      check("run_left", 32'(leftScore), k);
      idle();
      serveWindow("run");
    end
    ballXValue = 8'd231;
    step();
    check("win_left", 32'(leftScore), 9);
    check("win_gameOver", 32'(gameOver), 1);
    check("win_serve", 32'(serveReset), 1);
    ballDirection = 1'b0; ballXValue = 8'd250;
    for (int i = 0; i < 3; i++) begin
      step();
      check("over_right", 32'(rightScore), 2);
      check("over_left", 32'(leftScore), 9);
      check("over_gameOver", 32'(gameOver), 1);
      check("over_serve", 32'(serveReset), 1);
    end

    // newGame restarts the match
    idle();
    newGame = 1'b1;
    step();
    newGame = 1'b0;
    check("ng_left", 32'(leftScore), 0);
    check("ng_right", 32'(rightScore), 0);
    check("ng_gameOver", 32'(gameOver), 0);
    check("ng_serve", 32'(serveReset), 1);
    serveWindow("ng");

    // newGame wins over a same-cycle miss
    ballXValue = 8'd231; newGame = 1'b1;
    step();
    newGame = 1'b0;
    idle();
    check("ngmiss_left", 32'(leftScore), 0);
    check("ngmiss_serve", 32'(serveReset), 1);
    serveWindow("ngmiss");

    // asynchronous reset in the middle of a serve countdown
    ballXValue = 8'd231;
    step();
    check("pre_rst_left", 32'(leftScore), 1);
    idle();
    for (int i = 0; i < 3; i++) step();
    #2;
    reset = 1'b0;
    #1;
    check("arst_left", 32'(leftScore), 0);
    check("arst_serve", 32'(serveReset), 1);
    check("arst_gameOver", 32'(gameOver), 0);
    check("arst_changeX", 32'(changeXDirection), 0);
    checkRally("arst_rally", 0);
    #1;
    reset = 1'b1;
    serveWindow("arst");
    check("end_left", 32'(leftScore), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
